// File: rtl/fifo_pkg.sv
// Shared FIFO types and sizing: counter width, depth and the controller state encoding.
package fifo_pkg;

   localparam int unsigned COUNT_N = 3;
   localparam int unsigned DEPTH   = 2 ** COUNT_N;

   // One extra bit so a full FIFO is distinguishable from an empty one.
   typedef logic [COUNT_N:0] counter_t;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } fifo_state_e;

endpackage

// File: rtl/pointers.sv
// FIFO write/read counters with full/empty derived from their wrapped difference.
module pointers
   import fifo_pkg::*;
(
   input  logic     i_clk,
   input  logic     i_rst,
   input  logic     i_push,
   input  logic     i_pop,
   output logic     o_full,
   output logic     o_empty,
   output counter_t o_count_push,
   output counter_t o_count_pop
);

   counter_t r_count_push;
   counter_t r_count_pop;
   counter_t w_diff;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count_push <= '0;
         r_count_pop  <= '0;
      end else begin
         if (i_push) r_count_push <= r_count_push + counter_t'(1);
         if (i_pop)  r_count_pop  <= r_count_pop + counter_t'(1);
      end
   end

   assign w_diff       = r_count_push - r_count_pop;
   assign o_full       = (w_diff == counter_t'(DEPTH));
   assign o_empty      = (r_count_push == r_count_pop);
   assign o_count_push = r_count_push;
   assign o_count_pop  = r_count_pop;

endmodule

// File: rtl/sticky_flag.sv
// Sticky error bit: set wins over a same-cycle clear; async active-high reset.
module sticky_flag (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_set,
   input  logic i_clr,
   output logic o_q
);

   logic r_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q <= 1'b0;
      end else if (i_set) begin
         r_q <= 1'b1;
      end else if (i_clr) begin
         r_q <= 1'b0;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/fifo_ctrl_fsm.sv
// Request-side FIFO controller: grants push/pop against full/empty, tracks state,
// level and watermarks, and records sticky overflow/underflow/desync errors.
module fifo_ctrl_fsm
   import fifo_pkg::*;
#(
   parameter int unsigned AF_MARGIN = 1,
   parameter int unsigned AE_MARGIN = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_push_req,
   input  logic       i_pop_req,
   input  logic       i_clr_err,
   input  logic       i_full,
   input  logic       i_empty,
   input  counter_t   i_count_push,
   input  counter_t   i_count_pop,
   output logic       o_push,
   output logic       o_pop,
   output logic       o_rd_valid,
   output counter_t   o_level,
   output logic       o_almost_full,
   output logic       o_almost_empty,
   output logic       o_overflow,
   output logic       o_underflow,
   output logic       o_desync_err,
   output logic [1:0] o_fsm_state
);

   localparam counter_t    AF_LEVEL    = counter_t'(DEPTH - AF_MARGIN);
   localparam counter_t    AE_LEVEL    = counter_t'(AE_MARGIN);
   localparam counter_t    LVL_LAST    = counter_t'(DEPTH - 1);
   localparam fifo_state_e ST_AFTER_1ST = (DEPTH == 1) ? ST_FULL : ST_PARTIAL;

   fifo_state_e r_state;
   fifo_state_e w_state_next;
   logic        r_rd_valid;
   logic        w_push;
   logic        w_pop;
   logic        w_desync;
   counter_t    w_level;

   // Grants are suppressed during reset so an in-flight request cannot move the pointers.
   assign w_pop   = i_pop_req & ~i_empty & ~i_rst;
   assign w_push  = i_push_req & (~i_full | w_pop) & ~i_rst;
   assign w_level = i_count_push - i_count_pop;

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_EMPTY: begin
            if (w_push && !w_pop) w_state_next = ST_AFTER_1ST;
         end
         ST_PARTIAL: begin
            if (w_push && !w_pop && w_level == LVL_LAST) begin
               w_state_next = ST_FULL;
            end else if (w_pop && !w_push && w_level == counter_t'(1)) begin
               w_state_next = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_pop && !w_push) w_state_next = ST_PARTIAL;
         end
         default: w_state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_EMPTY;
         r_rd_valid <= FALSE;
      end else begin
         r_state    <= w_state_next;
         r_rd_valid <= w_pop;
      end
   end

   assign w_desync = ((r_state == ST_EMPTY) != i_empty) | ((r_state == ST_FULL) != i_full);

   sticky_flag u_overflow (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_set (i_push_req & ~w_push),
      .i_clr (i_clr_err),
      .o_q   (o_overflow)
   );

   sticky_flag u_underflow (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_set (i_pop_req & ~w_pop),
      .i_clr (i_clr_err),
      .o_q   (o_underflow)
   );

   sticky_flag u_desync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_set (w_desync),
      .i_clr (i_clr_err),
      .o_q   (o_desync_err)
   );

   assign o_push         = w_push;
   assign o_pop          = w_pop;
   assign o_rd_valid     = r_rd_valid;
   assign o_level        = w_level;
   assign o_almost_full  = (w_level >= AF_LEVEL);
   assign o_almost_empty = (w_level <= AE_LEVEL);
   assign o_fsm_state    = r_state;

endmodule
